pl_branch_predictor: RTL and testbench

- Fetch-side direction/target predictor for the 5-stage pipeline, consuming branch/jump resolution produced in Execute.
- Predicts taken/target for PCF each cycle from a direct-mapped table (tag, target, 2-bit saturating counter).
- Updates the table from Execute.
- Flags mispredictions with the corrected PC and the flush requests for Decode and Execute.

---
 rtl/pl_branch_predictor.sv | 112 +++++++++++
 tb/tb_pl_branch_predictor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pl_branch_predictor.sv
// pl_branch_predictor: direct-mapped fetch direction/target predictor with Execute-side resolve and update
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   PCF                        fetch PC looked up each cycle
//   PredTakenF, PredTargetF    combinational prediction for PCF
//   ValidE, IsJumpE, PCE       Execute control instruction info (ValidE=0 for bubbles)
//   TakenE, TargetE            resolved direction and target
//   PredTakenE, PredTargetE    prediction that travelled with the Execute instruction
//   MispredictE, RedirectPCE   redirect request and corrected PC
//   FlushD, FlushE             clear IF/ID and ID/EX on a redirect
//   BranchCount                resolved control instructions
//   MispredictCount            mispredictions
module pl_branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PCF,
   output logic            PredTakenF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic            ValidE,
   input  logic            IsJumpE,
   input  logic [XLEN-1:0] PCE,
   input  logic            TakenE,
   input  logic [XLEN-1:0] TargetE,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PredTargetE,
   output logic            MispredictE,
   output logic [XLEN-1:0] RedirectPCE,
   output logic            FlushD,
   output logic            FlushE,
   output logic [31:0]     BranchCount,
   output logic [31:0]     MispredictCount
);
   localparam int INDEX_W = $clog2(ENTRIES);
   localparam int TAG_W   = XLEN - INDEX_W - 2;
   logic               valid_q  [ENTRIES];
   logic               valid_d  [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [XLEN-1:0]    target_q [ENTRIES];
   logic [XLEN-1:0]    target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];
   logic [31:0]        branch_cnt_q, branch_cnt_d, mis_cnt_q, mis_cnt_d;
   logic [INDEX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0]   tag_f, tag_e;
   logic               hit_f, hit_e;
   logic [1:0]         ctr_e, ctr_upd;
   // Lookup: reads only registered state, so an update in flight is not bypassed
   always_comb begin
      idx_f       = PCF[INDEX_W+1:2];
      tag_f       = PCF[XLEN-1:INDEX_W+2];
      hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
      PredTakenF  = hit_f && ctr_q[idx_f][1];
      PredTargetF = PredTakenF ? target_q[idx_f] : PCF + XLEN'(4);
   end
   // Resolve: a bubble carrying a taken prediction also needs a redirect
   always_comb begin
      MispredictE = ValidE ? (TakenE != PredTakenE || (TakenE && TargetE != PredTargetE)) : PredTakenE;
      RedirectPCE = (ValidE && TakenE) ? TargetE : PCE + XLEN'(4);
      FlushD      = MispredictE;
      FlushE      = MispredictE;
   end
   // Update: single write port driven by the Execute resolution
   always_comb begin
      idx_e   = PCE[INDEX_W+1:2];
      tag_e   = PCE[XLEN-1:INDEX_W+2];
      hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
      ctr_e   = ctr_q[idx_e];
      ctr_upd = IsJumpE ? 2'b11 :
                TakenE  ? ((ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'b01) :
                          ((ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'b01);
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (ValidE && hit_e) begin
         ctr_d[idx_e] = ctr_upd;
         if (TakenE) target_d[idx_e] = TargetE;
      end else if (ValidE && TakenE) begin
         valid_d[idx_e]  = 1'b1;
         tag_d[idx_e]    = tag_e;
         target_d[idx_e] = TargetE;
         ctr_d[idx_e]    = IsJumpE ? 2'b11 : 2'b10;
      end
      branch_cnt_d = branch_cnt_q + {31'b0, ValidE};
      mis_cnt_d    = mis_cnt_q + {31'b0, MispredictE};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         branch_cnt_q <= '0;
         mis_cnt_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         target_q     <= target_d;
         ctr_q        <= ctr_d;
         branch_cnt_q <= branch_cnt_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end
   assign BranchCount     = branch_cnt_q;
   assign MispredictCount = mis_cnt_q;
endmodule

// File: tb/tb_pl_branch_predictor.sv
// tb_pl_branch_predictor: directed checks of prediction, resolve, update, aliasing, jumps and reset
module tb_pl_branch_predictor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        ValidE, IsJumpE, TakenE, PredTakenE;
   logic [31:0] PCE, TargetE, PredTargetE;
   logic        MispredictE, FlushD, FlushE;
   logic [31:0] RedirectPCE, BranchCount, MispredictCount;
   int          n_tests = 0;
   int          n_fail  = 0;
   pl_branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
      .ValidE(ValidE), .IsJumpE(IsJumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
      .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
      .RedirectPCE(RedirectPCE), .FlushD(FlushD), .FlushE(FlushE),
      .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ex(input logic v, input logic j, input logic [31:0] pce, input logic tk,
                     input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
      ValidE = v; IsJumpE = j; PCE = pce; TakenE = tk; TargetE = tgt; PredTakenE = pt; PredTargetE = ptg;
      #1;
   endtask
   task automatic idle();
      ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask
   task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      PCF = pc;
      #1;
      chk({tag, "_taken"}, {31'b0, PredTakenF}, {31'b0, tk});
      chk({tag, "_target"}, PredTargetF, tgt);
   endtask
   task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
      chk({tag, "_bcnt"}, BranchCount, b);
      chk({tag, "_mcnt"}, MispredictCount, m);
   endtask
   initial begin
      rst_n = 1'b0;
      PCF = 32'h100;
      idle();
      #12 rst_n = 1'b1;
      tick();
      look("rst", 32'h100, 1'b0, 32'h104);
      counts("rst", 0, 0);
      chk("rst_mis", {31'b0, MispredictE}, 0);
      // cold taken branch: mispredict, allocate ctr=10
      ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      chk("alloc_mis", {31'b0, MispredictE}, 1);
      chk("alloc_redir", RedirectPCE, 32'h80);
      chk("alloc_flush", {30'b0, FlushD, FlushE}, 2'b11);
      look("rdw", 32'h100, 1'b0, 32'h104);
      tick();
      idle();
      look("alloc", 32'h100, 1'b1, 32'h80);
      counts("alloc", 1, 1);
      // not taken twice: 10 -> 01 -> 00
      ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
      chk("nt1_mis", {31'b0, MispredictE}, 1);
      chk("nt1_redir", RedirectPCE, 32'h104);
      tick();
      idle();
      look("nt1", 32'h100, 1'b0, 32'h104);
      ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
      chk("nt2_mis", {31'b0, MispredictE}, 0);
      chk("nt2_redir", RedirectPCE, 32'h104);
      tick();
      idle();
      counts("nt2", 3, 2);
      // taken from saturated 00 -> 01, still predicted not taken
      ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      chk("sat_mis", {31'b0, MispredictE}, 1);
      tick();
      idle();
      look("sat", 32'h100, 1'b0, 32'h104);
      // alias at 0x140 evicts 0x100
      ex(1'b1, 1'b0, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
      chk("alias_mis", {31'b0, MispredictE}, 1);
      tick();
      idle();
      look("alias_old", 32'h100, 1'b0, 32'h104);
      look("alias_new", 32'h140, 1'b1, 32'h200);
      counts("alias", 5, 4);
      // JAL allocates strongly taken
      ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
      chk("jal_mis", {31'b0, MispredictE}, 1);
      tick();
      idle();
      look("jal", 32'h300, 1'b1, 32'h400);
      ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 32'h400);
      chk("jal_ok_mis", {31'b0, MispredictE}, 0);
      tick();
      ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 32'h400);
      chk("jalr_mis", {31'b0, MispredictE}, 1);
      chk("jalr_redir", RedirectPCE, 32'h500);
      tick();
      idle();
      look("jalr", 32'h300, 1'b1, 32'h500);
      counts("jalr", 8, 6);
      // one not-taken step from 11 must still predict taken
      ex(1'b1, 1'b0, 32'h300, 1'b0, 32'h304, 1'b1, 32'h500);
      chk("dec11_mis", {31'b0, MispredictE}, 1);
      tick();
      idle();
      look("dec11", 32'h300, 1'b1, 32'h500);
      // bubble carrying a taken prediction
      ex(1'b0, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'h500);
      chk("bub_mis", {31'b0, MispredictE}, 1);
      chk("bub_redir", RedirectPCE, 32'h304);
      tick();
      idle();
      counts("bub", 9, 8);
      look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
      // reset asserted during an update cycle
      ex(1'b1, 1'b0, 32'h104, 1'b1, 32'h600, 1'b0, 32'h108);
      rst_n = 1'b0;
      tick();
      idle();
      #2 rst_n = 1'b1;
      tick();
      look("rstupd", 32'h104, 1'b0, 32'h108);
      look("rstold", 32'h300, 1'b0, 32'h304);
      counts("rstupd", 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
